fir_out_decim_fifo: RTL

- Downstream stage of the 4-tap transposed-form FIR.
- Takes the FIR's 19-bit output word, rounds and saturates it to 16 bits, and decimates by DECIM.
- Buffers the result in a small first-word-fall-through FIFO with a valid/ready output handshake.
- Feeds the next consumer, such as a serializer or capture logic.

---
 rtl/fir_out_decim_fifo.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fir_out_decim_fifo.sv
// fir_out_decim_fifo
//   Output stage for the 4-tap transposed FIR. It rounds the FIR word half-up,
//   drops SHIFT LSBs, saturates the result to OUT_W bits and decimates by
//   DECIM. Results are held in a DEPTH-entry first-word-fall-through FIFO that
//   has a valid/ready output.
//
//   Build option: define FIR_DECIM_AVG_EN to replace pick-phase-0 decimation
//   with a sum of DECIM samples. The sum is rounded with SHIFT+log2(DECIM)
//   fractional bits. DECIM must then be a power of 2.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active high
//   din       in   [IN_W]  FIR output sample, signed
//   din_vld   in   din carries a new sample
//   dout      out  [OUT_W] FIFO head (last popped value when empty)
//   dout_vld  out  FIFO not empty
//   dout_rdy  in   consumer accepts dout
//   sat       out  one-cycle pulse, round-stage sample was clipped
//   drop_cnt  out  [8] saturating count of words lost to a full FIFO
module fir_out_decim_fifo #(
  parameter int IN_W  = 19,
  parameter int OUT_W = 16,
  parameter int SHIFT = 3,
  parameter int DECIM = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  din,
  input  logic             din_vld,
  output logic [OUT_W-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             sat,
  output logic [7:0]       drop_cnt
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW   = $clog2(DEPTH);
`ifdef FIR_DECIM_AVG_EN
  localparam int LG_D = $clog2(DECIM);
`else
  localparam int LG_D = 0;
`endif
  localparam int SUM_W = IN_W + LG_D;
  localparam int SH    = SHIFT + LG_D;
  localparam int EXT_W = SUM_W + 1;

  localparam logic [PH_W-1:0]         PH_LAST = PH_W'(DECIM - 1);
  localparam logic signed [EXT_W-1:0] MAX_V   = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_V   = ~MAX_V;
  localparam logic signed [EXT_W-1:0] RND     = EXT_W'(1) << (SH - 1);

  logic [PH_W-1:0]         phase_q, phase_d;
  logic                    kept;
  logic signed [SUM_W-1:0] din_ext;
  logic signed [SUM_W-1:0] src;
  logic signed [EXT_W-1:0] rnd_sum, shifted;
  logic                    clip_hi, clip_lo;

  logic [OUT_W-1:0] rs_data_q, rs_data_d;
  logic             rs_vld_q, rs_vld_d;
  logic             sat_q, sat_d;

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0] last_q, last_d;
  logic [7:0]       drop_q, drop_d;
  logic             full, push, pop, drop;

  assign din_ext = SUM_W'($signed(din));

  always_comb begin
    phase_d = phase_q;
    if (din_vld) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
  end

`ifdef FIR_DECIM_AVG_EN
  logic signed [SUM_W-1:0] acc_q, acc_d;
  logic signed [SUM_W-1:0] sum;

  // Phase 0 restarts the sum so no explicit clear is needed between groups.
  always_comb begin
    sum   = ((phase_q == '0) ? '0 : acc_q) + din_ext;
    acc_d = acc_q;
    if (din_vld) acc_d = sum;
    kept  = din_vld && (phase_q == PH_LAST);
    src   = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end
`else
  always_comb begin
    kept = din_vld && (phase_q == '0);
    src  = din_ext;
  end
`endif

  // One extra bit of headroom lets the rounding constant be added without wrapping.
  always_comb begin
    rnd_sum   = EXT_W'(src) + RND;
    shifted   = rnd_sum >>> SH;
    clip_hi   = shifted > MAX_V;
    clip_lo   = shifted < MIN_V;
    rs_data_d = rs_data_q;
    if (kept) rs_data_d = clip_hi ? MAX_V[OUT_W-1:0] :
                          clip_lo ? MIN_V[OUT_W-1:0] : shifted[OUT_W-1:0];
    rs_vld_d  = kept;
    sat_d     = kept && (clip_hi || clip_lo);
  end

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    full     = (cnt_q == (AW+1)'(DEPTH));
    dout_vld = (cnt_q != '0);
    pop      = dout_vld && dout_rdy;
    push     = rs_vld_q && (!full || dout_rdy);
    drop     = rs_vld_q && full && !dout_rdy;

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = rs_data_q;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    last_d = pop ? mem_q[rd_ptr_q] : last_q;
    drop_d = (drop && drop_q != 8'hFF) ? drop_q + 1'b1 : drop_q;
    dout   = dout_vld ? mem_q[rd_ptr_q] : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      rs_data_q <= '0;
      rs_vld_q  <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      last_q    <= '0;
      drop_q    <= '0;
    end else begin
      phase_q   <= phase_d;
      rs_data_q <= rs_data_d;
      rs_vld_q  <= rs_vld_d;
      sat_q     <= sat_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      drop_q    <= drop_d;
    end
  end

  assign sat      = sat_q;
  assign drop_cnt = drop_q;

endmodule
